// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg : shared widths, FSM state encoding and packed binary32 layout for
//          the FP add/sub normalize/round/pack back end.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = FRAC_W + 5;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 2 * BIAS + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        OUT   = 2'd3
    } norm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

`default_nettype wire

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne : combinational round-to-nearest-even of a normalized mantissa
//                {hidden, frac, G, R, S}; reports carry-out and inexact.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fp_round_rne #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic [FRAC_W+3:0] mant,
    input  logic [EXP_W:0]    exp,
    output logic [FRAC_W-1:0] frac,
    output logic [EXP_W:0]    exp_out,
    output logic              carry,
    output logic              inexact
);
    import fp_pkg::*;

    logic                w_inc;
    logic [FRAC_W+1:0]   w_sum;

    always_comb begin
        w_inc   = mant[2] & (mant[1] | mant[0] | mant[3]);
        w_sum   = {1'b0, mant[FRAC_W+3:3]} + {{(FRAC_W+1){1'b0}}, w_inc};
        carry   = w_sum[FRAC_W+1];
        frac    = w_sum[FRAC_W-1:0];
        inexact = |mant[2:0];
        // A subnormal that rounds up into the hidden bit becomes the smallest normal.
        exp_out = exp;
        if (exp == '0 && w_sum[FRAC_W]) begin
            exp_out = {{EXP_W{1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_norm_pack.sv
// -----------------------------------------------------------------------------
// fp_norm_pack : iterative normalize, RNE round and binary32 pack of a raw
//                signed-magnitude sum. Optional flags: FP_NORM_PACK_FLAGS_EN.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fp_norm_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int MANT_W = FRAC_W + 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic                    in_eff_sub,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_data
`ifdef FP_NORM_PACK_FLAGS_EN
    ,
    output logic [3:0]              out_flags
`endif
);
    import fp_pkg::*;

    localparam logic [EXP_W:0] c_EXP_ONE  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [EXP_W:0] c_EXP_ALL1 = {1'b0, {EXP_W{1'b1}}};

    norm_state_t              r_state, w_state_nx;
    logic                     r_sign, w_sign_nx;
    logic                     r_eff_sub, w_eff_sub_nx;
    logic [EXP_W:0]           r_exp, w_exp_nx;
    logic [MANT_W-1:0]        r_mant, w_mant_nx;
    logic [EXP_W+FRAC_W:0]    r_out_data, w_out_data_nx;

    logic [FRAC_W-1:0]        w_rnd_frac;
    logic [EXP_W:0]           w_rnd_exp;
    logic                     w_rnd_carry;
    logic                     w_rnd_inexact;
    logic [EXP_W:0]           w_exp_fin;

`ifdef FP_NORM_PACK_FLAGS_EN
    logic [3:0]               r_flags, w_flags_nx;
    assign out_flags = r_flags;
`endif

    fp_round_rne #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_round (
        .mant    (r_mant[FRAC_W+3:0]),
        .exp     (r_exp),
        .frac    (w_rnd_frac),
        .exp_out (w_rnd_exp),
        .carry   (w_rnd_carry),
        .inexact (w_rnd_inexact)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign out_data  = r_out_data;

    always_comb begin
        w_state_nx    = r_state;
        w_sign_nx     = r_sign;
        w_eff_sub_nx  = r_eff_sub;
        w_exp_nx      = r_exp;
        w_mant_nx     = r_mant;
        w_out_data_nx = r_out_data;
`ifdef FP_NORM_PACK_FLAGS_EN
        w_flags_nx    = r_flags;
`endif
        // Exponent +1 from a rounding carry leaves the fraction field at zero.
        w_exp_fin     = w_rnd_exp + {{EXP_W{1'b0}}, w_rnd_carry};

        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_sign_nx    = in_sign;
                    w_eff_sub_nx = in_eff_sub;
                    w_exp_nx     = {1'b0, in_exp};
                    w_mant_nx    = in_mant;
                    w_state_nx   = NORM;
                end
            end
            NORM: begin
                if (r_mant == '0) begin
                    w_out_data_nx = {r_sign & ~r_eff_sub, {(EXP_W+FRAC_W){1'b0}}};
`ifdef FP_NORM_PACK_FLAGS_EN
                    w_flags_nx    = 4'b0001;
`endif
                    w_state_nx    = OUT;
                end else if (r_mant[MANT_W-1]) begin
                    w_mant_nx  = {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
                    w_exp_nx   = r_exp + c_EXP_ONE;
                    w_state_nx = ROUND;
                end else if (r_mant[MANT_W-2]) begin
                    w_state_nx = ROUND;
                end else if (r_exp <= c_EXP_ONE) begin
                    w_exp_nx   = '0;
                    w_state_nx = ROUND;
                end else begin
                    w_mant_nx  = {r_mant[MANT_W-2:0], 1'b0};
                    w_exp_nx   = r_exp - c_EXP_ONE;
                end
            end
            ROUND: begin
                if (w_exp_fin >= c_EXP_ALL1) begin
                    w_out_data_nx = {r_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                end else begin
                    w_out_data_nx = {r_sign, w_exp_fin[EXP_W-1:0], w_rnd_frac};
                end
`ifdef FP_NORM_PACK_FLAGS_EN
                w_flags_nx[3] = (w_exp_fin >= c_EXP_ALL1);
                w_flags_nx[2] = (w_exp_fin == '0) && w_rnd_inexact;
                w_flags_nx[1] = w_rnd_inexact;
                w_flags_nx[0] = (w_exp_fin == '0) && (w_rnd_frac == '0);
`endif
                w_state_nx = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sign     <= 1'b0;
            r_eff_sub  <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_out_data <= '0;
`ifdef FP_NORM_PACK_FLAGS_EN
            r_flags    <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_sign     <= w_sign_nx;
            r_eff_sub  <= w_eff_sub_nx;
            r_exp      <= w_exp_nx;
            r_mant     <= w_mant_nx;
            r_out_data <= w_out_data_nx;
`ifdef FP_NORM_PACK_FLAGS_EN
            r_flags    <= w_flags_nx;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_pack : directed and randomized checks of fp_norm_pack against an
//                   arithmetic binary32 rounding model.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_fp_norm_pack;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic        in_eff_sub;
    logic [7:0]  in_exp;
    logic [27:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
`ifdef FP_NORM_PACK_FLAGS_EN
    logic [3:0]  out_flags;
    logic [3:0]  flags_cap;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_norm_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_eff_sub (in_eff_sub),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef FP_NORM_PACK_FLAGS_EN
        ,
        .out_flags  (out_flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Value = mant * 2^(exp-127-26); round that real value to binary32 (RNE).
    function automatic logic [31:0] ref_pack(input logic s, input logic es,
                                             input int e_in, input logic [27:0] m);
        int     p, e, sh;
        longint q, rem, half;
        fp32_t  r;
        if (m == 28'd0) return {s & ~es, 31'd0};
        p = 27;
        while (!m[p]) p--;
        e  = e_in + p - 26;
        sh = (e >= 1) ? (p - 23) : (4 - e_in);
        if (sh > 0) begin
            q    = longint'(m) >> sh;
            rem  = longint'(m) & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = longint'(m) << (-sh);
        end
        r.sign = s;
        if (e >= 1) begin
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                r.exp  = 8'hFF;
                r.frac = 23'd0;
            end else begin
                r.exp  = 8'(e);
                r.frac = q[22:0];
            end
        end else begin
            r.exp  = q[23] ? 8'd1 : 8'd0;
            r.frac = q[22:0];
        end
        return r;
    endfunction

    function automatic int ref_lat(input int e_in, input logic [27:0] m);
        int p, n;
        if (m == 28'd0) return 2;
        p = 27;
        while (!m[p]) p--;
        n = (p >= 26) ? 0 : (((26 - p) < (e_in - 1)) ? (26 - p) : (e_in - 1));
        return 3 + n;
    endfunction

    task automatic run_op(input logic s, input logic es, input logic [7:0] e,
                          input logic [27:0] m, output logic [31:0] data, output int lat);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
        end
        in_valid   = 1'b1;
        in_sign    = s;
        in_eff_sub = es;
        in_exp     = e;
        in_mant    = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            #1;
        end while (!out_valid && cnt < 64);
        if (!out_valid) check("timeout_out_valid", {31'd0, out_valid}, 32'd1);
        data = out_data;
`ifdef FP_NORM_PACK_FLAGS_EN
        flags_cap = out_flags;
`endif
        lat = cnt + 1;
    endtask

    task automatic do_dir(input string tag, input logic s, input logic es, input logic [7:0] e,
                          input logic [27:0] m, input logic [31:0] exp_d, input int exp_lat);
        logic [31:0] d;
        int          lat;
        run_op(s, es, e, m, d, lat);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        int          lat;
        int          k;
        logic        seen;
        logic        s, es;
        logic [7:0]  e;
        logic [27:0] m;
        int          p;

        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_eff_sub = 1'b0;
        in_exp = 8'd0; in_mant = 28'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);

        do_dir("carry",    1'b0, 1'b0, 8'h7F, 28'hB000000, 32'h40300000, 3);
`ifdef FP_NORM_PACK_FLAGS_EN
        check("flags_carry", {28'd0, flags_cap}, 32'h0);
`endif
        do_dir("cancel",   1'b1, 1'b1, 8'h85, 28'h0000000, 32'h00000000, 2);
        do_dir("lnorm3",   1'b0, 1'b0, 8'h7F, 28'h0800000, 32'h3E000000, 6);
        do_dir("rne_cy",   1'b0, 1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 3);
        do_dir("rne_tie",  1'b0, 1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 3);
        do_dir("ovf",      1'b0, 1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 3);
`ifdef FP_NORM_PACK_FLAGS_EN
        check("flags_ovf", {28'd0, flags_cap}, 32'h8);
`endif
        do_dir("sub_zero", 1'b1, 1'b0, 8'h01, 28'h0000004, 32'h80000000, 3);
        do_dir("sub_up",   1'b0, 1'b0, 8'h01, 28'h3FFFFFC, 32'h00800000, 3);

        // Backpressure: result must hold and new requests must be refused.
        out_ready = 1'b0;
        run_op(1'b0, 1'b0, 8'h7F, 28'hB000000, d, lat);
        check("bp_first", d, 32'h40300000);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_exp   = 8'h10;
            in_mant  = 28'($urandom());
            @(posedge clk); #1;
            check("bp_data", out_data, 32'h40300000);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        do_dir("after_bp", 1'b0, 1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 3);

        // Reset during a long left-normalization discards the operation.
        in_valid = 1'b1; in_sign = 1'b0; in_eff_sub = 1'b0;
        in_exp = 8'h7F; in_mant = 28'h0000100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_out_data", out_data, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 300; i++) begin
            s  = 1'($urandom());
            es = 1'($urandom());
            k  = $urandom_range(0, 7);
            if (k < 2)       e = 8'($urandom_range(1, 30));
            else if (k == 2) e = 8'($urandom_range(250, 254));
            else             e = 8'($urandom_range(1, 254));
            if ($urandom_range(0, 15) == 0) begin
                m = 28'd0;
            end else begin
                p = $urandom_range(0, 27);
                m = 28'($urandom()) & ((28'd1 << p) - 28'd1);
                m[p] = 1'b1;
            end
            run_op(s, es, e, m, d, lat);
            check("rnd_data", d, ref_pack(s, es, int'(e), m));
            check("rnd_lat", 32'(lat), 32'(ref_lat(int'(e), m)));
            k = $urandom_range(0, 2);
            if (k != 0) begin
                out_ready = 1'b0;
                repeat (k) begin
                    @(posedge clk); #1;
                end
                check("rnd_hold", out_data, d);
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
